rx_deframer: RTL and testbench

RX_DEFRAMER -- requirements
Module: rx_deframer

---
 rtl/link_pkg.sv | 22 ++
 rtl/link_crc8.sv | 20 ++
 rtl/rx_deframer.sv | 184 ++++++++++++++++++
 tb/tb_rx_deframer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared link-layer constants, FSM state encoding and counter helper
// for the receive deframer.
package link_pkg;

    localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
    localparam int         MAX_LEN_DEFAULT = 16;
    localparam logic [7:0] CRC8_POLY       = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CRC     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    // Saturating 8-bit event counter step.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
        return (en && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/link_crc8.sv
// One-byte CRC-8 update: poly 0x07, MSB-first, no reflection, no final XOR.
module link_crc8
    import link_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rx_deframer.sv
// Receive deframer: parses SOF/LEN/payload/CRC, buffers a checked frame
// and drains it on a valid/ready stream, with saturating event counters.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | hunting for the SOF byte
// ST_LEN     | SOF seen, next byte is the payload length
// ST_PAYLOAD | writing payload bytes into the buffer
// ST_CRC     | next byte is compared against the running CRC
// ST_DRAIN   | frame verified, streaming the buffer out
module rx_deframer
    import link_pkg::*;
#(
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int          MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic       clk_recovered,
    input  logic       rst_n,
    input  logic [7:0] d_in,
    input  logic       d_in_valid,
    input  logic       reframe,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       busy,
    output logic [7:0] frame_ok_cnt,
    output logic [7:0] crc_err_cnt,
    output logic [7:0] drop_cnt
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [IDX_W-1:0]  wr_idx, rd_idx, last_idx;
    logic [7:0]        crc_q, crc_next;
    logic [7:0]        buf_mem [MAX_LEN];

    logic start, load_len, upd_crc, wr_en, rd_adv;
    logic ok_evt, crc_evt, drop_evt;
    logic len_ok, xfer, drain;

    link_crc8 u_crc8 (
        .crc_in  (crc_q),
        .data    (d_in),
        .crc_out (crc_next)
    );

    assign last_idx = IDX_W'(len_q - LEN_W'(1));
    assign len_ok   = (d_in != 8'h00) && (int'(d_in) <= MAX_LEN);
    assign drain    = (state_q == ST_DRAIN);

    // m_data is gated so it reads zero outside DRAIN (buffer itself is unreset).
    assign m_valid = drain;
    assign m_data  = drain ? buf_mem[rd_idx] : 8'h00;
    assign m_last  = drain && (rd_idx == last_idx);
    assign busy    = (state_q != ST_IDLE);
    assign xfer    = m_valid && m_ready;

    always_ff @(posedge clk_recovered or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        load_len = 1'b0;
        upd_crc  = 1'b0;
        wr_en    = 1'b0;
        rd_adv   = 1'b0;
        ok_evt   = 1'b0;
        crc_evt  = 1'b0;
        drop_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_in_valid && (d_in == SOF)) begin
                    state_d = ST_LEN;
                    start   = 1'b1;
                end
            end
            ST_LEN: begin
                if (reframe) begin
                    state_d  = ST_IDLE;
                    drop_evt = 1'b1;
                end else if (d_in_valid) begin
                    if (len_ok) begin
                        state_d  = ST_PAYLOAD;
                        load_len = 1'b1;
                        upd_crc  = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        drop_evt = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (reframe) begin
                    state_d  = ST_IDLE;
                    drop_evt = 1'b1;
                end else if (d_in_valid) begin
                    wr_en   = 1'b1;
                    upd_crc = 1'b1;
                    if (wr_idx == last_idx) begin
                        state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (reframe) begin
                    state_d  = ST_IDLE;
                    drop_evt = 1'b1;
                end else if (d_in_valid) begin
                    if (d_in == crc_q) begin
                        state_d = ST_DRAIN;
                        ok_evt  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        crc_evt = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (d_in_valid && (d_in == SOF)) begin
                    drop_evt = 1'b1;
                end
                if (xfer) begin
                    rd_adv = 1'b1;
                    if (m_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_recovered or negedge rst_n) begin
        if (!rst_n) begin
            crc_q        <= 8'h00;
            len_q        <= '0;
            wr_idx       <= '0;
            rd_idx       <= '0;
            frame_ok_cnt <= 8'h00;
            crc_err_cnt  <= 8'h00;
            drop_cnt     <= 8'h00;
        end else begin
            if (start) begin
                crc_q  <= 8'h00;
                wr_idx <= '0;
            end else if (upd_crc) begin
                crc_q <= crc_next;
            end
            if (load_len) begin
                len_q <= LEN_W'(d_in);
            end
            if (wr_en) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
            if (ok_evt) begin
                rd_idx <= '0;
            end else if (rd_adv) begin
                rd_idx <= m_last ? '0 : rd_idx + IDX_W'(1);
            end
            frame_ok_cnt <= sat_inc8(frame_ok_cnt, ok_evt);
            crc_err_cnt  <= sat_inc8(crc_err_cnt, crc_evt);
            drop_cnt     <= sat_inc8(drop_cnt, drop_evt);
        end
    end

    always_ff @(posedge clk_recovered) begin
        if (wr_en) begin
            buf_mem[wr_idx] <= d_in;
        end
    end

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: vector table of whole frames plus
// hand-written stall, reframe, drain-SOF, saturation and reset sequences.
module tb_rx_deframer;

    logic       clk_recovered;
    logic       rst_n;
    logic [7:0] d_in;
    logic       d_in_valid;
    logic       reframe;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       busy;
    logic [7:0] frame_ok_cnt;
    logic [7:0] crc_err_cnt;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_ok   = 0;
    int exp_crc  = 0;
    int exp_drop = 0;

    logic [7:0] beat_d [$];
    logic       beat_l [$];

    typedef struct {
        logic [0:7][7:0] b;
        int              n;
        int              beats;
        logic [7:0]      first_d;
        logic [7:0]      last_d;
        int              d_ok;
        int              d_crc;
        int              d_drop;
    } vec_t;

    vec_t vecs [6];

    rx_deframer dut (
        .clk_recovered (clk_recovered),
        .rst_n         (rst_n),
        .d_in          (d_in),
        .d_in_valid    (d_in_valid),
        .reframe       (reframe),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .frame_ok_cnt  (frame_ok_cnt),
        .crc_err_cnt   (crc_err_cnt),
        .drop_cnt      (drop_cnt)
    );

    initial clk_recovered = 1'b0;
    always #5 clk_recovered = ~clk_recovered;

    always @(negedge clk_recovered) begin
        if (rst_n && m_valid && m_ready) begin
            beat_d.push_back(m_data);
            beat_l.push_back(m_last);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Bitwise reference: feedback per input bit, MSB first.
    function automatic logic [7:0] crc_bit(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic send(input logic [7:0] b);
        d_in       = b;
        d_in_valid = 1'b1;
        @(posedge clk_recovered); #1;
        d_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (busy && (k < lim)) begin
            @(posedge clk_recovered); #1;
            k++;
        end
        chk("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_ok_cnt"},   {24'b0, frame_ok_cnt}, exp_ok);
        chk({tag, "_crc_cnt"},  {24'b0, crc_err_cnt},  exp_crc);
        chk({tag, "_drop_cnt"}, {24'b0, drop_cnt},     exp_drop);
    endtask

    initial begin
        logic [7:0] crc;
        int         k;

        vecs[0] = '{b: {8'hA5, 8'h01, 8'h00, 8'h15, 32'h0}, n: 4, beats: 1,
                    first_d: 8'h00, last_d: 8'h00, d_ok: 1, d_crc: 0, d_drop: 0};
        vecs[1] = '{b: {8'hA5, 8'h01, 8'h00, 8'h16, 32'h0}, n: 4, beats: 0,
                    first_d: 8'h00, last_d: 8'h00, d_ok: 0, d_crc: 1, d_drop: 0};
        vecs[2] = '{b: {8'hA5, 8'h00, 48'h0}, n: 2, beats: 0,
                    first_d: 8'h00, last_d: 8'h00, d_ok: 0, d_crc: 0, d_drop: 1};
        vecs[3] = '{b: {8'hA5, 8'h11, 48'h0}, n: 2, beats: 0,
                    first_d: 8'h00, last_d: 8'h00, d_ok: 0, d_crc: 0, d_drop: 1};
        vecs[4] = '{b: {8'h33, 8'h7E, 8'hA5, 8'h01, 8'h00, 8'h15, 16'h0}, n: 6, beats: 1,
                    first_d: 8'h00, last_d: 8'h00, d_ok: 1, d_crc: 0, d_drop: 0};
        vecs[5] = '{b: {8'hA5, 8'h02, 8'h12, 8'h34, 8'h27, 24'h0}, n: 5, beats: 2,
                    first_d: 8'h12, last_d: 8'h34, d_ok: 1, d_crc: 0, d_drop: 0};

        rst_n      = 1'b0;
        d_in       = 8'h00;
        d_in_valid = 1'b0;
        reframe    = 1'b0;
        m_ready    = 1'b1;
        #12;
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_last",  {31'b0, m_last},  32'd0);
        chk("rst_m_data",  {24'b0, m_data},  32'd0);
        chk("rst_busy",    {31'b0, busy},    32'd0);
        chk_counters("rst");
        @(negedge clk_recovered);
        rst_n = 1'b1;
        @(posedge clk_recovered); #1;

        for (int v = 0; v < 6; v++) begin
            beat_d.delete();
            beat_l.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                send(vecs[v].b[i]);
            end
            wait_idle(40);
            @(posedge clk_recovered); #1;
            exp_ok   = sat(exp_ok + vecs[v].d_ok);
            exp_crc  = sat(exp_crc + vecs[v].d_crc);
            exp_drop = sat(exp_drop + vecs[v].d_drop);
            chk($sformatf("vec%0d_beats", v), beat_d.size(), vecs[v].beats);
            if (vecs[v].beats > 0 && beat_d.size() == vecs[v].beats) begin
                chk($sformatf("vec%0d_first", v), {24'b0, beat_d[0]}, {24'b0, vecs[v].first_d});
                chk($sformatf("vec%0d_lastd", v), {24'b0, beat_d[beat_d.size()-1]}, {24'b0, vecs[v].last_d});
                for (int i = 0; i < beat_d.size(); i++) begin
                    chk($sformatf("vec%0d_mlast%0d", v, i), {31'b0, beat_l[i]},
                        (i == beat_d.size() - 1) ? 32'd1 : 32'd0);
                end
            end
            chk_counters($sformatf("vec%0d", v));
        end

        // 16-byte frame with a 5-cycle stall after the fifth beat
        beat_d.delete();
        beat_l.delete();
        crc = crc_bit(8'h00, 8'h10);
        send(8'hA5);
        send(8'h10);
        for (int i = 0; i < 16; i++) begin
            crc = crc_bit(crc, 8'(i));
            send(8'(i));
        end
        send(crc);
        k = 0;
        while (beat_d.size() < 5 && k < 40) begin
            @(posedge clk_recovered); #1;
            k++;
        end
        m_ready = 1'b0;
        chk("stall_reached", beat_d.size(), 5);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk_recovered);
            chk("stall_valid", {31'b0, m_valid}, 32'd1);
            chk("stall_data",  {24'b0, m_data},  32'h05);
            chk("stall_last",  {31'b0, m_last},  32'd0);
        end
        @(posedge clk_recovered); #1;
        m_ready = 1'b1;
        wait_idle(40);
        exp_ok = sat(exp_ok + 1);
        chk("long_beats", beat_d.size(), 16);
        if (beat_d.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("long_d%0d", i), {24'b0, beat_d[i]}, i);
                chk($sformatf("long_l%0d", i), {31'b0, beat_l[i]}, (i == 15) ? 32'd1 : 32'd0);
            end
        end
        chk_counters("long");

        // reframe after the third payload byte, colliding with a fourth valid byte
        beat_d.delete();
        beat_l.delete();
        send(8'hA5);
        send(8'h04);
        send(8'h10);
        send(8'h11);
        send(8'h12);
        d_in       = 8'h13;
        d_in_valid = 1'b1;
        reframe    = 1'b1;
        @(posedge clk_recovered); #1;
        d_in_valid = 1'b0;
        reframe    = 1'b0;
        exp_drop   = sat(exp_drop + 1);
        chk("reframe_busy", {31'b0, busy}, 32'd0);
        chk_counters("reframe");
        reframe = 1'b1;
        @(posedge clk_recovered); #1;
        reframe = 1'b0;
        chk("reframe_idle_drop", {24'b0, drop_cnt}, exp_drop);
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send(8'h15);
        wait_idle(20);
        exp_ok = sat(exp_ok + 1);
        chk("post_reframe_beats", beat_d.size(), 1);
        if (beat_d.size() == 1) begin
            chk("post_reframe_data", {24'b0, beat_d[0]}, 32'h00);
            chk("post_reframe_last", {31'b0, beat_l[0]}, 32'd1);
        end
        chk_counters("post_reframe");

        // SOF and reframe while a frame waits in DRAIN
        beat_d.delete();
        beat_l.delete();
        m_ready = 1'b0;
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send(8'h15);
        exp_ok = sat(exp_ok + 1);
        send(8'hA5);
        send(8'h01);
        reframe = 1'b1;
        @(posedge clk_recovered); #1;
        reframe  = 1'b0;
        exp_drop = sat(exp_drop + 1);
        chk("drain_valid", {31'b0, m_valid}, 32'd1);
        chk("drain_data",  {24'b0, m_data},  32'h00);
        chk("drain_last",  {31'b0, m_last},  32'd1);
        chk("drain_busy",  {31'b0, busy},    32'd1);
        chk_counters("drain");
        m_ready = 1'b1;
        wait_idle(20);
        chk("drain_beats", beat_d.size(), 1);
        if (beat_d.size() == 1) begin
            chk("drain_beat_data", {24'b0, beat_d[0]}, 32'h00);
        end

        // crc_err_cnt saturation
        for (int f = 0; f < 300; f++) begin
            send(8'hA5);
            send(8'h01);
            send(8'h00);
            send(8'h16);
        end
        exp_crc = sat(exp_crc + 300);
        chk_counters("sat");

        // reset while draining discards the frame uncounted
        beat_d.delete();
        beat_l.delete();
        m_ready = 1'b0;
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send(8'h15);
        chk("pre_rst_valid", {31'b0, m_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_ok   = 0;
        exp_crc  = 0;
        exp_drop = 0;
        chk("midrst_valid", {31'b0, m_valid}, 32'd0);
        chk("midrst_data",  {24'b0, m_data},  32'd0);
        chk("midrst_busy",  {31'b0, busy},    32'd0);
        chk_counters("midrst");
        @(negedge clk_recovered);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        @(posedge clk_recovered); #1;
        chk("postrst_beats", beat_d.size(), 0);
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send(8'h15);
        wait_idle(20);
        exp_ok = 1;
        chk("postrst_frame_beats", beat_d.size(), 1);
        chk_counters("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
